// File: rtl/aes_round_sched.sv
// -----------------------------------------------------------------------------
// aes_round_sched
//
// Round scheduler for the shared iterative AES round datapath. Arbitrates
// between two requesters, loads the granted requester's state/key into the
// datapath, issues NR round steps with round index and Rcon, and hands
// completion back over a valid/ready response handshake.
//
// Build option:
//   AES_ROUND_SCHED_RR_EN  defined   -> round-robin between simultaneous
//                                       requests (last-grant pointer used)
//                          undefined -> fixed priority, requester 0 wins
//
// Parameters:
//   NR            rounds per block, 1..14
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         asynchronous active-high reset
//   req_valid_i   [1:0] per-requester job request (held until accepted)
//   req_ready_o   [1:0] one-hot accept, only in LOAD
//   rsp_valid_o   [1:0] one-hot completion, only in RESP
//   rsp_ready_i   [1:0] per-requester completion accept
//   dp_sel_o      datapath input mux select (granted requester)
//   dp_load_o     datapath load pulse (plaintext/key + initial AddRoundKey)
//   dp_step_o     datapath start-one-round pulse
//   dp_last_o     final round flag (no MixColumns)
//   dp_round_o    [3:0] current round index 1..NR, else 0
//   dp_rcon_o     [7:0] key-schedule round constant, else 0
//   dp_done_i     datapath round complete, only looked at in WAIT
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no job; pick a requester when any req_valid is high
// LOAD   | accept cycle; datapath captures inputs if the request is held
// STEP   | one-cycle round start pulse
// WAIT   | round in flight, waiting for dp_done
// RESP   | completion offered to the granted requester
// -----------------------------------------------------------------------------
module aes_round_sched #(
    parameter int unsigned NR = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_valid_i,
    output logic [1:0] req_ready_o,
    output logic [1:0] rsp_valid_o,
    input  logic [1:0] rsp_ready_i,
    output logic       dp_sel_o,
    output logic       dp_load_o,
    output logic       dp_step_o,
    output logic       dp_last_o,
    output logic [3:0] dp_round_o,
    output logic [7:0] dp_rcon_o,
    input  logic       dp_done_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] NR_L = 4'(NR);

    // GF(2^8) doubling used to advance Rcon between rounds
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q,  rcon_d;
`ifdef AES_ROUND_SCHED_RR_EN
    logic       last_q,  last_d;
`endif

    logic [1:0] req_ready_q;
    logic [1:0] rsp_valid_q;
    logic       dp_sel_q;
    logic       dp_step_q;
    logic       dp_last_q;
    logic [3:0] dp_round_q;
    logic [7:0] dp_rcon_q;

    logic       in_round_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        round_d = round_q;
        rcon_d  = rcon_q;
`ifdef AES_ROUND_SCHED_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid_i != 2'b00) begin
`ifdef AES_ROUND_SCHED_RR_EN
                    // On a tie, serve whoever was not served last.
                    if (req_valid_i == 2'b11) begin
                        grant_d = ~last_q;
                    end else begin
                        grant_d = req_valid_i[1];
                    end
`else
                    grant_d = ~req_valid_i[0];
`endif
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (req_valid_i[grant_q]) begin
                    round_d = 4'd1;
                    rcon_d  = 8'h01;
                    state_d = S_STEP;
                end else begin
                    // Requester withdrew before the load took effect.
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dp_done_i) begin
                    if (round_q == NR_L) begin
                        state_d = S_RESP;
                    end else begin
                        round_d = round_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                        state_d = S_STEP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready_i[grant_q]) begin
`ifdef AES_ROUND_SCHED_RR_EN
                    last_d = grant_q;
`endif
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_round_d = (state_d == S_STEP) || (state_d == S_WAIT);

    // -------------------------------------------------------------------------
    // State and registered outputs. Outputs are decoded from the next state
    // so they line up with the state register without a combinational path.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            grant_q     <= 1'b0;
            round_q     <= 4'd0;
            rcon_q      <= 8'h00;
`ifdef AES_ROUND_SCHED_RR_EN
            last_q      <= 1'b1;
`endif
            req_ready_q <= 2'b00;
            rsp_valid_q <= 2'b00;
            dp_sel_q    <= 1'b0;
            dp_step_q   <= 1'b0;
            dp_last_q   <= 1'b0;
            dp_round_q  <= 4'd0;
            dp_rcon_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            round_q     <= round_d;
            rcon_q      <= rcon_d;
`ifdef AES_ROUND_SCHED_RR_EN
            last_q      <= last_d;
`endif
            req_ready_q <= (state_d == S_LOAD) ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
            rsp_valid_q <= (state_d == S_RESP) ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
            dp_sel_q    <= (state_d != S_IDLE) ? grant_d : 1'b0;
            dp_step_q   <= (state_d == S_STEP);
            dp_last_q   <= in_round_d && (round_d == NR_L);
            dp_round_q  <= in_round_d ? round_d : 4'd0;
            dp_rcon_q   <= in_round_d ? rcon_d : 8'h00;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign dp_sel_o    = dp_sel_q;
    assign dp_step_o   = dp_step_q;
    assign dp_last_o   = dp_last_q;
    assign dp_round_o  = dp_round_q;
    assign dp_rcon_o   = dp_rcon_q;

    // Load only fires while the granted request is still asserted in LOAD.
    assign dp_load_o   = |(req_ready_q & req_valid_i);

endmodule

// File: tb/tb_aes_round_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_round_sched
//
// Self-checking bench for aes_round_sched. A job-level reference model tracks
// which phase of a job the scheduler should be in and derives every output
// from it each cycle; directed sections pin the model with literal timelines.
// -----------------------------------------------------------------------------
module tb_aes_round_sched;

    localparam int NR = 10;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [1:0] req_valid_i = 2'b00;
    logic [1:0] rsp_ready_i = 2'b00;
    logic       dp_done_i = 1'b0;
    logic [1:0] req_ready_o;
    logic [1:0] rsp_valid_o;
    logic       dp_sel_o;
    logic       dp_load_o;
    logic       dp_step_o;
    logic       dp_last_o;
    logic [3:0] dp_round_o;
    logic [7:0] dp_rcon_o;

    aes_round_sched #(.NR(NR)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .dp_sel_o    (dp_sel_o),
        .dp_load_o   (dp_load_o),
        .dp_step_o   (dp_step_o),
        .dp_last_o   (dp_last_o),
        .dp_round_o  (dp_round_o),
        .dp_rcon_o   (dp_rcon_o),
        .dp_done_i   (dp_done_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rc_tab [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    task automatic timed_out(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s actual=timeout required=event t=%0t", nm, $time);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: job phase 0 idle, 1 accept, 2 round start, 3 round busy,
    // 4 response; plus granted requester, last served requester, round number.
    // ------------------------------------------------------------------------
    int m_ph   = 0;
    int m_g    = 0;
    int m_last = 1;
    int m_rnd  = 0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_ph = 0; m_g = 0; m_last = 1; m_rnd = 0;
        end else begin
            case (m_ph)
                0: if (req_valid_i != 2'b00) begin
`ifdef AES_ROUND_SCHED_RR_EN
                       if (req_valid_i == 2'b11) m_g = (m_last == 0) ? 1 : 0;
                       else                      m_g = req_valid_i[1] ? 1 : 0;
`else
                       m_g = req_valid_i[0] ? 0 : 1;
`endif
                       m_ph = 1;
                   end
                1: if (req_valid_i[m_g]) begin m_rnd = 1; m_ph = 2; end
                   else m_ph = 0;
                2: m_ph = 3;
                3: if (dp_done_i) begin
                       if (m_rnd == NR) m_ph = 4;
                       else begin m_rnd = m_rnd + 1; m_ph = 2; end
                   end
                default: if (rsp_ready_i[m_g]) begin m_last = m_g; m_ph = 0; end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        logic [1:0] onehot;
        logic       busy;
        onehot = (m_g == 1) ? 2'b10 : 2'b01;
        busy   = (m_ph == 2) || (m_ph == 3);
        chk("m_req_ready", req_ready_o, (m_ph == 1) ? onehot : 2'b00);
        chk("m_dp_load",   dp_load_o,   (m_ph == 1) && req_valid_i[m_g]);
        chk("m_rsp_valid", rsp_valid_o, (m_ph == 4) ? onehot : 2'b00);
        chk("m_dp_sel",    dp_sel_o,    (m_ph != 0) ? m_g[0] : 1'b0);
        chk("m_dp_step",   dp_step_o,   m_ph == 2);
        chk("m_dp_last",   dp_last_o,   busy && (m_rnd == NR));
        chk("m_dp_round",  dp_round_o,  busy ? m_rnd : 0);
        chk("m_dp_rcon",   dp_rcon_o,   busy ? rc_tab[m_rnd-1] : 8'h00);
    end

    // ------------------------------------------------------------------------
    // dp_done driver: 0 = tied high, 1 = random, 2 = done on 3rd busy cycle
    // (and high everywhere outside the busy phase, which must be ignored).
    // ------------------------------------------------------------------------
    int mode = 0;
    int dcnt = 0;
    always @(posedge clk_i) begin
        logic waiting;
        #2;
        waiting = (dp_round_o != 4'd0) && !dp_step_o;
        if (dp_step_o)    dcnt = 0;
        else if (waiting) dcnt = dcnt + 1;
        case (mode)
            0:       dp_done_i = 1'b1;
            1:       dp_done_i = 1'($urandom_range(0, 1));
            default: dp_done_i = waiting ? (dcnt == 3) : 1'b1;
        endcase
    end

    task automatic do_reset();
        rst_i = 1'b1;
        req_valid_i = 2'b00;
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b0;
    endtask

    task automatic wait_accept(input string nm);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (req_ready_o != 2'b00) begin ok = 1; break; end
        end
        if (!ok) timed_out(nm);
        @(posedge clk_i); #2 req_valid_i = 2'b00;
    endtask

    task automatic finish_job(input string nm);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o != 2'b00) begin ok = 1; break; end
        end
        if (!ok) timed_out(nm);
        @(posedge clk_i); #2;
    endtask

    initial begin
        // ---- reset state ----
        @(negedge clk_i);
        chk("rst_outputs", {req_ready_o, rsp_valid_o, dp_sel_o, dp_load_o, dp_step_o,
                            dp_last_o, dp_round_o, dp_rcon_o}, 32'h0);
        do_reset();

        // ---- single job, literal timeline ----
        mode = 0;
        rsp_ready_i = 2'b11;
        @(posedge clk_i); #2 req_valid_i = 2'b01;
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk_i); #2;
            if (c == 2) req_valid_i = 2'b00;
            @(negedge clk_i);
            chk("sj_req_ready", req_ready_o, (c == 1) ? 2'b01 : 2'b00);
            chk("sj_load",      dp_load_o,   c == 1);
            chk("sj_step",      dp_step_o,   (c % 2 == 0) && (c >= 2) && (c <= 20));
            chk("sj_round",     dp_round_o,  (c >= 2 && c <= 21) ? c / 2 : 0);
            chk("sj_rcon",      dp_rcon_o,   (c >= 2 && c <= 21) ? rc_tab[c/2-1] : 8'h00);
            chk("sj_last",      dp_last_o,   (c == 20) || (c == 21));
            chk("sj_rsp",       rsp_valid_o, (c == 22) ? 2'b01 : 2'b00);
        end
        @(posedge clk_i); #2;
        @(negedge clk_i);
        chk("sj_idle_rsp", rsp_valid_o, 2'b00);

        // ---- dp_done delayed 3 cycles per round ----
        mode = 2;
        @(posedge clk_i); #2 req_valid_i = 2'b10;
        wait_accept("dly_accept");
        begin
            int nsteps = 0;
            int last_step = 0;
            bit seen = 0;
            for (int cyc = 0; cyc < 300; cyc++) begin
                @(negedge clk_i);
                if (dp_step_o) begin
                    if (nsteps > 0) chk("dly_gap", cyc - last_step, 4);
                    last_step = cyc;
                    nsteps++;
                end
                if (rsp_valid_o != 2'b00) begin
                    chk("dly_resp_gap", cyc - last_step, 4);
                    chk("dly_nsteps", nsteps, NR);
                    chk("dly_rsp", rsp_valid_o, 2'b10);
                    seen = 1;
                    break;
                end
            end
            if (!seen) timed_out("dly_resp");
        end
        @(posedge clk_i); #2;
        mode = 0;

        // ---- response back-pressure ----
        rsp_ready_i = 2'b00;
        req_valid_i = 2'b01;
        wait_accept("bp_accept");
        begin
            bit seen = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk_i);
                if (rsp_valid_o != 2'b00) begin seen = 1; break; end
            end
            if (!seen) timed_out("bp_resp");
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #2;
            @(negedge clk_i);
            chk("bp_hold_rsp",  rsp_valid_o, 2'b01);
            chk("bp_hold_step", dp_step_o,   1'b0);
        end
        @(posedge clk_i); #2 rsp_ready_i = 2'b01;
        @(negedge clk_i);
        chk("bp_rsp_last", rsp_valid_o, 2'b01);
        @(posedge clk_i); #2;
        @(negedge clk_i);
        chk("bp_idle_rsp", rsp_valid_o, 2'b00);
        chk("bp_idle_sel", dp_sel_o,    1'b0);
        rsp_ready_i = 2'b11;

        // ---- withdrawal during LOAD ----
        @(posedge clk_i); #2 req_valid_i = 2'b01;
        @(posedge clk_i); #2 req_valid_i = 2'b00;
        @(negedge clk_i);
        chk("wd_ready", req_ready_o, 2'b01);
        chk("wd_load",  dp_load_o,   1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("wd_no_step",  dp_step_o,   1'b0);
            chk("wd_no_ready", req_ready_o, 2'b00);
        end

        // ---- reset in WAIT of round 5 ----
        @(posedge clk_i); #2 req_valid_i = 2'b01;
        wait_accept("rw_accept");
        begin
            bit seen = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk_i);
                if (dp_round_o == 4'd5 && !dp_step_o) begin seen = 1; break; end
            end
            if (!seen) timed_out("rw_round5");
        end
        #1 rst_i = 1'b1;
        #1;
        chk("rw_outputs", {req_ready_o, rsp_valid_o, dp_sel_o, dp_load_o, dp_step_o,
                           dp_last_o, dp_round_o, dp_rcon_o}, 32'h0);
        @(posedge clk_i); #2 rst_i = 1'b0; req_valid_i = 2'b10;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rw_ready1", req_ready_o, 2'b10);
        @(posedge clk_i); #2 req_valid_i = 2'b00;
        finish_job("rw_finish");

        // ---- simultaneous requests, 4 jobs ----
        do_reset();
        req_valid_i = 2'b11;
        begin
            logic [0:0] grants [4];
            int ngr = 0;
`ifdef AES_ROUND_SCHED_RR_EN
            logic [0:0] exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
            logic [0:0] exp_g [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
            for (int i = 0; i < 400 && ngr < 4; i++) begin
                @(negedge clk_i);
                if (req_ready_o != 2'b00) begin
                    grants[ngr] = dp_sel_o;
                    ngr++;
                end
            end
            if (ngr < 4) timed_out("arb_grants");
            for (int k = 0; k < ngr; k++) chk("arb_grant", grants[k], exp_g[k]);
        end
        @(posedge clk_i); #2 req_valid_i = 2'b00;
        finish_job("arb_finish");

        // ---- randomized traffic ----
        mode = 1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i); #2;
            req_valid_i = 2'($urandom_range(0, 3));
            rsp_ready_i = 2'($urandom_range(0, 3));
            rst_i       = ($urandom_range(0, 499) == 0);
        end
        @(posedge clk_i); #2 rst_i = 1'b0; req_valid_i = 2'b00;
        repeat (4) @(posedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
